// File: rtl/rom_dl_router.sv
// ROM download router: decodes the ioctl byte stream into N equal-size regions,
// drives one-hot region write ports and tracks byte count, checksum and fill status.
module rom_dl_router #(
    parameter int         NUM_REGIONS  = 15,
    parameter int         REGION_AW    = 12,
    parameter logic [7:0] TARGET_INDEX = 8'd0
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic [NUM_REGIONS-1:0] rom_cs,
    output logic [REGION_AW-1:0]   rom_addr,
    output logic [7:0]             rom_data,
    output logic                   rom_wr,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [24:0]            bytes_loaded,
    output logic [7:0]             checksum,
    output logic [NUM_REGIONS-1:0] region_loaded
);

    localparam int AW = 25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FINISH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                 state;
    logic                   dl_q;
    logic                   err_flag;
    logic                   rise;
    logic                   fall;
    logic [AW-1:0]          region_p0;
    logic                   in_range_p0;
    logic [NUM_REGIONS-1:0] cs_p0;
    logic                   wr_vld_p0;

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        return (&v) ? v : v + AW'(1);
    endfunction

    function automatic logic [7:0] wrap_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    assign rise = ioctl_download & ~dl_q;
    assign fall = ~ioctl_download & dl_q;
    assign busy = (state == S_LOAD) || (state == S_FINISH);

    // Stage p0: decode the incoming byte's region and decide acceptance
    assign region_p0   = ioctl_addr >> REGION_AW;
    assign in_range_p0 = (region_p0 < AW'(NUM_REGIONS));
    assign wr_vld_p0   = (state == S_LOAD) && ioctl_wr && in_range_p0;

    always_comb begin
        cs_p0 = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            cs_p0[i] = (region_p0 == AW'(i));
        end
    end

    // Stage p1: registered write port, progress counters and download FSM
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= S_IDLE;
            dl_q          <= 1'b0;
            err_flag      <= 1'b0;
            rom_cs        <= '0;
            rom_addr      <= '0;
            rom_data      <= '0;
            rom_wr        <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            bytes_loaded  <= '0;
            checksum      <= '0;
            region_loaded <= '0;
        end else begin
            dl_q   <= ioctl_download;
            rom_wr <= 1'b0;
            rom_cs <= '0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    // A rise for another index leaves done/error untouched
                    if (rise && (ioctl_index == TARGET_INDEX)) begin
                        state         <= S_LOAD;
                        bytes_loaded  <= '0;
                        checksum      <= '0;
                        region_loaded <= '0;
                        err_flag      <= 1'b0;
                        done          <= 1'b0;
                        error         <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (wr_vld_p0) begin
                        rom_wr        <= 1'b1;
                        rom_cs        <= cs_p0;
                        rom_addr      <= ioctl_addr[REGION_AW-1:0];
                        rom_data      <= ioctl_dout;
                        bytes_loaded  <= sat_inc(bytes_loaded);
                        checksum      <= wrap_add(checksum, ioctl_dout);
                        region_loaded <= region_loaded | cs_p0;
                    end else if (ioctl_wr) begin
                        err_flag <= 1'b1;
                    end
                    if (fall) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    if ((&region_loaded) && !err_flag) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_dl_router.sv
// Scoreboard bench for rom_dl_router: expected writes are queued when driven and
// checked (content and exact cycle) when rom_wr appears; status checked after each download.
module tb_rom_dl_router;

    localparam int NR = 15;
    localparam int RAW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic [NR-1:0] rom_cs;
    logic [RAW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_wr;
    logic          busy;
    logic          done;
    logic          error;
    logic [24:0]   bytes_loaded;
    logic [7:0]    checksum;
    logic [NR-1:0] region_loaded;

    rom_dl_router #(.NUM_REGIONS(NR), .REGION_AW(RAW), .TARGET_INDEX(8'd0)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_wr(rom_wr),
        .busy(busy), .done(done), .error(error),
        .bytes_loaded(bytes_loaded), .checksum(checksum), .region_loaded(region_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0]  cs;
        logic [RAW-1:0] addr;
        logic [7:0]     data;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_wr = 0;

    // Reference model state
    logic          m_load = 1'b0;
    logic          m_err = 1'b0;
    logic          m_done = 1'b0;
    logic          m_error = 1'b0;
    logic [24:0]   m_bytes = '0;
    logic [7:0]    m_sum = '0;
    logic [NR-1:0] m_rl = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_wr) begin
                n_wr++;
                if (sb.size() == 0) begin
                    chk("spurious_wr", 32'(rom_wr), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_cs", 32'(rom_cs), 32'(e.cs));
                    chk("wr_addr", 32'(rom_addr), 32'(e.addr));
                    chk("wr_data", 32'(rom_data), 32'(e.data));
                    chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (rom_cs != '0) begin
                chk("cs_idle", 32'(rom_cs), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        if (!m_load && idx == 8'd0) begin
            m_load = 1'b1; m_err = 1'b0; m_done = 1'b0; m_error = 1'b0;
            m_bytes = '0; m_sum = '0; m_rl = '0;
        end
        tick();
    endtask

    // Leaves ioctl_wr high so consecutive calls give back-to-back strobes
    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        int r;
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (m_load) begin
            r = int'(a >> RAW);
            if (r < NR) begin
                exp_t e;
                e.cs = NR'(1) << r;
                e.addr = a[RAW-1:0];
                e.data = d;
                e.cyc = cyc + 1;
                sb.push_back(e);
                m_bytes = m_bytes + 25'd1;
                m_sum = m_sum + d;
                m_rl = m_rl | (NR'(1) << r);
            end else begin
                m_err = 1'b1;
            end
        end
        tick();
    endtask

    task automatic end_dl(input string tag);
        logic was;
        was = m_load;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        m_load = 1'b0;
        tick();
        chk({tag, "_busy_finish"}, 32'(busy), 32'(was));
        chk({tag, "_done_finish"}, 32'(done), was ? 32'd0 : 32'(m_done));
        tick();
        if (was) begin
            m_done = (&m_rl) && !m_err;
            m_error = !m_done;
        end
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_error"}, 32'(error), 32'(m_error));
        chk({tag, "_bytes"}, 32'(bytes_loaded), 32'(m_bytes));
        chk({tag, "_sum"}, 32'(checksum), 32'(m_sum));
        chk({tag, "_rl"}, 32'(region_loaded), 32'(m_rl));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"}, 32'(rom_wr), 32'd0);
        chk({tag, "_cs"}, 32'(rom_cs), 32'd0);
        chk({tag, "_outs"}, 32'({rom_addr, rom_data, busy, done, error}), 32'd0);
        chk({tag, "_cnt"}, 32'({bytes_loaded, checksum}), 32'd0);
        chk({tag, "_rl"}, 32'(region_loaded), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        #13;
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Full load of every region, byte = addr[7:0]
        start_dl(8'd0);
        chk("load_busy", 32'(busy), 32'd1);
        wr0 = n_wr;
        for (int a = 0; a < 'hF000; a++) wr_byte(25'(a), 8'(a));
        end_dl("full");
        chk("full_wr_count", 32'(n_wr - wr0), 32'd61440);
        chk("full_const", 32'({bytes_loaded, checksum, region_loaded}),
            32'({25'h0F000, 8'h00, 15'h7FFF}) & 32'hFFFF_FFFF);
        chk("full_done_const", 32'({done, error}), 32'b10);

        // Index filter: other index ignored, done and counters kept
        start_dl(8'd1);
        wr_byte(25'h0000, 8'h55);
        end_dl("idx1");
        chk("idx1_bytes_kept", 32'(bytes_loaded), 32'h0F000);
        start_dl(8'd0);
        chk("idx0_clear_done", 32'(done), 32'd0);
        chk("idx0_clear_bytes", 32'(bytes_loaded), 32'd0);

        // Region boundary
        wr_byte(25'h0FFF, 8'hA1);
        ioctl_wr = 1'b0;
        tick();
        wr_byte(25'h1000, 8'hB2);
        end_dl("boundary");

        // Checksum wrap with back-to-back writes
        start_dl(8'd0);
        wr_byte(25'h0000, 8'hFF);
        wr_byte(25'h0001, 8'h02);
        end_dl("wrap");
        chk("wrap_sum_const", 32'(checksum), 32'h01);
        chk("wrap_bytes_const", 32'(bytes_loaded), 32'd2);

        // All regions touched plus one out-of-range byte
        start_dl(8'd0);
        for (int r = 0; r < NR; r++) wr_byte(25'(r << RAW) + 25'(r), 8'(r + 3));
        wr_byte(25'h0F000, 8'h77);
        end_dl("oor");
        chk("oor_flags", 32'({done, error}), 32'b01);

        // Last region missing
        start_dl(8'd0);
        for (int r = 0; r < NR - 1; r++) wr_byte(25'(r << RAW) + 25'h7, 8'(r));
        end_dl("partial");
        chk("partial_rl_const", 32'(region_loaded), 32'h3FFF);

        // Asynchronous reset with a write pending
        start_dl(8'd0);
        wr_byte(25'h0010, 8'h11);
        wr_byte(25'h0011, 8'h22);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_load = 1'b0;
        #1;
        chk_all_zero("async_rst");
        ioctl_wr = 1'b0;
        tick();
        rst_n = 1'b1;
        start_dl(8'd0);
        chk("rerise_busy", 32'(busy), 32'd1);
        chk("rerise_bytes", 32'(bytes_loaded), 32'd0);
        wr_byte(25'h0020, 8'h33);
        end_dl("rerise");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_dl_router.md
Name: rom_dl_router

Overview:
- Parametrised ROM download router for the MiSTer ioctl stream. Generalises fixed-map ROM chip-select decoding to N equal-size regions.
- Registers each ioctl byte and presents it to exactly one region's download port (region-local address, one-hot CS, 1-cycle write strobe).
- Tracks download progress: byte count, 8-bit additive checksum, per-region fill flags. Reports done/error so the core can hold CPUs in reset until every ROM is present.
- Sits between hps_io and the eprom/dpram_dc download ports.

Parameters:
NUM_REGIONS, 15, number of equal-size ROM regions (1..32)
REGION_AW, 12, log2 of region size in bytes; also rom_addr width
TARGET_INDEX, 0, ioctl_index value this router accepts

Ports:
CLK  in  1  system/download clock
RESET_N  in  1  asynchronous active-low reset
ioctl_download  in  1  download active level from hps_io
ioctl_index  in  8  download index
ioctl_wr  in  1  byte-valid strobe
ioctl_addr  in  25  byte address within download
ioctl_dout  in  8  byte data
rom_cs  out  NUM_REGIONS  one-hot region select, valid with rom_wr
rom_addr  out  REGION_AW  region-local address (ioctl_addr[REGION_AW-1:0])
rom_data  out  8  registered data byte
rom_wr  out  1  write strobe, one cycle per accepted byte
busy  out  1  high in LOAD and FINISH
done  out  1  download complete and valid
error  out  1  download complete but invalid
bytes_loaded  out  25  count of accepted bytes
checksum  out  8  mod-256 sum of accepted bytes
region_loaded  out  NUM_REGIONS  bit i set once any byte written to region i

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, dl_q=0, err_flag=0. If ioctl_download is high at reset release, the next edge check sees a rise.
- Edge detect: dl_q <= ioctl_download each cycle. rise = download & !dl_q; fall = !download & dl_q.
- States: IDLE, LOAD, FINISH, DONE, ERROR.
- IDLE/DONE/ERROR, on rise with ioctl_index==TARGET_INDEX -> LOAD.
  - On entry: bytes_loaded, checksum, region_loaded and err_flag cleared; done=0, error=0.
- Index latching: the index is sampled only at rise. A rise with a different index is ignored and the state is held, so done/error remain as they were. Index changes during LOAD are ignored.
- LOAD, per ioctl_wr=1:
  - Region r = ioctl_addr >> REGION_AW.
  - In range (r < NUM_REGIONS): next cycle rom_wr=1, rom_cs=1<<r, rom_addr, rom_data registered. Also next cycle: bytes_loaded+1, checksum+dout (wraps mod 256), region_loaded[r]=1.
  - Out of range: no rom_wr, rom_cs stays 0, counters unchanged, err_flag=1 (sticky).
  - Outside LOAD, ioctl_wr is ignored entirely.
  - Back-to-back ioctl_wr on consecutive cycles is supported at full rate: latency 1, throughput 1 byte/cycle.
- rom_cs and rom_wr are 0 on every cycle without an accepted write; rom_addr/rom_data hold their last value.
- LOAD, on fall -> FINISH. A write accepted in the same cycle as fall still completes its rom_wr next cycle.
- FINISH: one cycle, no writes.
  - If every region_loaded bit is set and err_flag=0 -> DONE (done=1).
  - Otherwise -> ERROR (error=1).
- done and error are mutually exclusive. Both are 0 in IDLE, LOAD and FINISH.
- bytes_loaded saturates at 2^25-1; this is unreachable in range but must be defined.
- Reset mid-LOAD: any pending rom_wr is dropped; all state is cleared to IDLE.

Test Plan:
- Full load, defaults: addresses 0x0000..0xEFFF, byte = addr[7:0] -> 61440 rom_wr pulses; region i gets cs bit i over addr 0x000..0xFFF; bytes_loaded=0xF000; checksum=0x00; region_loaded=0x7FFF; done=1 two cycles after fall.
- Boundary: single writes at 0x0FFF then 0x1000 -> rom_cs=0x0001/rom_addr=0xFFF, then rom_cs=0x0002/rom_addr=0x000, each exactly one cycle after ioctl_wr.
- Out-of-range/partial: full load plus a write at 0xF000 -> no rom_wr for it, bytes_loaded=0xF000, error=1, done=0. Separately, a load omitting 0xE000..0xEFFF -> region_loaded=0x3FFF, error=1.
- Index filter: with done=1, a download with index 1 writing 0x0000 -> no rom_wr, done stays 1, counters unchanged. A following index-0 rise clears done and counters.
- Checksum wrap: bytes 0xFF,0x02 to 0x0000,0x0001 -> checksum=0x01, bytes_loaded=2. Back-to-back ioctl_wr yields back-to-back rom_wr.
- Async reset mid-LOAD with ioctl_wr high: RESET_N low -> rom_wr=0 and all outputs 0 immediately. Release with download still high -> re-enters LOAD, counters from 0.
